versatile_fifo_dpram_be: RTL and testbench

//  Single-clock true dual-port RAM with per-byte write enables, selectable read-during-write

---
 rtl/versatile_fifo_dpram_be_if.sv | 28 ++
 rtl/versatile_fifo_dpram_be.sv | 208 ++++++++++++++++++++
 tb/tb_versatile_fifo_dpram_be.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/versatile_fifo_dpram_be_if.sv
// rtl/versatile_fifo_dpram_be_if.sv - port bundle for the byte-enable dual-port RAM
interface versatile_fifo_dpram_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  clr;
  logic                  init_busy;
  logic                  en_a, we_a, q_vld_a, par_inj_a, par_err_a;
  logic [NB-1:0]         be_a;
  logic [ADDR_WIDTH-1:0] adr_a;
  logic [DATA_WIDTH-1:0] d_a, q_a;
  logic                  en_b, we_b, q_vld_b, par_err_b;
  logic [NB-1:0]         be_b;
  logic [ADDR_WIDTH-1:0] adr_b;
  logic [DATA_WIDTH-1:0] d_b, q_b;

  modport master (
    output clr, en_a, we_a, be_a, adr_a, d_a, par_inj_a, en_b, we_b, be_b, adr_b, d_b,
    input  init_busy, q_a, q_vld_a, par_err_a, q_b, q_vld_b, par_err_b
  );
  modport slave (
    input  clr, en_a, we_a, be_a, adr_a, d_a, par_inj_a, en_b, we_b, be_b, adr_b, d_b,
    output init_busy, q_a, q_vld_a, par_err_a, q_b, q_vld_b, par_err_b
  );
endinterface

// File: rtl/versatile_fifo_dpram_be.sv
// rtl/versatile_fifo_dpram_be.sv - byte-enable true dual-port RAM with zero-fill sweep
// Per-lane even parity storage is built when SDC_DPRAM_PARITY_EN is defined.
module versatile_fifo_dpram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input logic                      clk,
  input logic                      rst_n,
  versatile_fifo_dpram_be_if.slave bus
);
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] cnt;
  logic                  acc_a, acc_b, wr_a, wr_b;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_a, rd_b, q1_a, q1_b;
  logic                  vld1_a, vld1_b, err1_a, err1_b;

`ifdef SDC_DPRAM_PARITY_EN
  logic [NB-1:0] pmem [DEPTH];
  logic [NB-1:0] wp_a, wp_b, rp_a, rp_b, p1_a, p1_b;

  function automatic logic [NB-1:0] lane_par(input logic [DATA_WIDTH-1:0] w);
    lane_par = '0;
    for (int i = 0; i < NB; i++) lane_par[i] = ^w[i*BYTE_WIDTH +: BYTE_WIDTH];
  endfunction

  assign wp_a = lane_par(bus.d_a) ^ {NB{bus.par_inj_a}};
  assign wp_b = lane_par(bus.d_b);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  // A clr pulse drops the port accesses of its cycle.
  always_comb begin
    state_nxt     = state;
    acc_a         = 1'b0;
    acc_b         = 1'b0;
    bus.init_busy = (state == S_INIT);
    case (state)
      S_INIT: if (!bus.clr && (&cnt)) state_nxt = S_RUN;
      S_RUN: begin
        if (bus.clr) begin
          state_nxt = S_INIT;
        end else begin
          acc_a = bus.en_a;
          acc_b = bus.en_b;
        end
      end
      default: state_nxt = S_INIT;
    endcase
    wr_a = acc_a & bus.we_a;
    wr_b = acc_b & bus.we_b;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                           cnt <= '0;
    else if (state == S_INIT && !bus.clr) cnt <= cnt + 1'b1;
    else                                  cnt <= '0;
  end

  // Port B lanes are written first so that port A wins on a shared lane.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == S_INIT) begin
        mem[cnt] <= '0;
`ifdef SDC_DPRAM_PARITY_EN
        pmem[cnt] <= '0;
`endif
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (wr_b && bus.be_b[i]) begin
            mem[bus.adr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.d_b[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef SDC_DPRAM_PARITY_EN
            pmem[bus.adr_b][i] <= wp_b[i];
`endif
          end
        end
        for (int i = 0; i < NB; i++) begin
          if (wr_a && bus.be_a[i]) begin
            mem[bus.adr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.d_a[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef SDC_DPRAM_PARITY_EN
            pmem[bus.adr_a][i] <= wp_a[i];
`endif
          end
        end
      end
    end
  end

  // Forwarding follows the same B-then-A lane priority as the array write.
  always_comb begin
    rd_a = mem[bus.adr_a];
    rd_b = mem[bus.adr_b];
`ifdef SDC_DPRAM_PARITY_EN
    rp_a = pmem[bus.adr_a];
    rp_b = pmem[bus.adr_b];
`endif
    if (RDW_MODE != 0) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b && bus.be_b[i] && bus.adr_b == bus.adr_a) begin
          rd_a[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.d_b[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef SDC_DPRAM_PARITY_EN
          rp_a[i] = wp_b[i];
`endif
        end
        if (wr_a && bus.be_a[i]) begin
          rd_a[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.d_a[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef SDC_DPRAM_PARITY_EN
          rp_a[i] = wp_a[i];
`endif
        end
        if (wr_b && bus.be_b[i]) begin
          rd_b[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.d_b[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef SDC_DPRAM_PARITY_EN
          rp_b[i] = wp_b[i];
`endif
        end
        if (wr_a && bus.be_a[i] && bus.adr_a == bus.adr_b) begin
          rd_b[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.d_a[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef SDC_DPRAM_PARITY_EN
          rp_b[i] = wp_a[i];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q1_a   <= '0;
      q1_b   <= '0;
      vld1_a <= 1'b0;
      vld1_b <= 1'b0;
    end else begin
      vld1_a <= acc_a;
      vld1_b <= acc_b;
      if (acc_a) q1_a <= rd_a;
      if (acc_b) q1_b <= rd_b;
    end
  end

`ifdef SDC_DPRAM_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1_a <= '0;
      p1_b <= '0;
    end else begin
      if (acc_a) p1_a <= rp_a;
      if (acc_b) p1_b <= rp_b;
    end
  end
  assign err1_a = vld1_a && (p1_a != lane_par(q1_a));
  assign err1_b = vld1_b && (p1_b != lane_par(q1_b));
`else
  logic unused_par_inj;
  assign unused_par_inj = bus.par_inj_a;
  assign err1_a = 1'b0;
  assign err1_b = 1'b0;
`endif

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] q2_a, q2_b;
      logic                  vld2_a, vld2_b, err2_a, err2_b;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q2_a   <= '0;
          q2_b   <= '0;
          vld2_a <= 1'b0;
          vld2_b <= 1'b0;
          err2_a <= 1'b0;
          err2_b <= 1'b0;
        end else begin
          vld2_a <= vld1_a;
          vld2_b <= vld1_b;
          err2_a <= err1_a;
          err2_b <= err1_b;
          if (vld1_a) q2_a <= q1_a;
          if (vld1_b) q2_b <= q1_b;
        end
      end
      assign bus.q_a       = q2_a;
      assign bus.q_b       = q2_b;
      assign bus.q_vld_a   = vld2_a;
      assign bus.q_vld_b   = vld2_b;
      assign bus.par_err_a = err2_a;
      assign bus.par_err_b = err2_b;
    end else begin : g_noreg
      assign bus.q_a       = q1_a;
      assign bus.q_b       = q1_b;
      assign bus.q_vld_a   = vld1_a;
      assign bus.q_vld_b   = vld1_b;
      assign bus.par_err_a = err1_a;
      assign bus.par_err_b = err1_b;
    end
  endgenerate
endmodule

// File: tb/tb_versatile_fifo_dpram_be.sv
// tb/tb_versatile_fifo_dpram_be.sv - bench for versatile_fifo_dpram_be
// dut0: RDW_MODE=0/OUT_REG=0, dut1: RDW_MODE=1/OUT_REG=1, sharing one stimulus stream.
module tb_versatile_fifo_dpram_be;
`ifdef SDC_DPRAM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic        en_a, we_a;
    logic [3:0]  be_a;
    logic [8:0]  adr_a;
    logic [31:0] d_a;
    logic        inj;
    logic        en_b, we_b;
    logic [3:0]  be_b;
    logic [8:0]  adr_b;
    logic [31:0] d_b;
    logic [31:0] qa0, qb0, qa1, qb1;
    logic [3:0]  perr;  // {pa0, pb0, pa1, pb1}
  } vec_t;

  typedef struct packed {
    logic [31:0] q;
    logic        pe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic mon_on = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb_a0[$], sb_b0[$], sb_a1[$], sb_b1[$];
  vec_t vec[16];
  vec_t idle_v;

  always #5 clk = ~clk;

  versatile_fifo_dpram_be_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(9)) bus0 ();
  versatile_fifo_dpram_be_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(9)) bus1 ();

  assign bus1.clr = bus0.clr;
  assign bus1.en_a = bus0.en_a;
  assign bus1.we_a = bus0.we_a;
  assign bus1.be_a = bus0.be_a;
  assign bus1.adr_a = bus0.adr_a;
  assign bus1.d_a = bus0.d_a;
  assign bus1.par_inj_a = bus0.par_inj_a;
  assign bus1.en_b = bus0.en_b;
  assign bus1.we_b = bus0.we_b;
  assign bus1.be_b = bus0.be_b;
  assign bus1.adr_b = bus0.adr_b;
  assign bus1.d_b = bus0.d_b;

  versatile_fifo_dpram_be #(.RDW_MODE(0), .OUT_REG(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  versatile_fifo_dpram_be #(.RDW_MODE(1), .OUT_REG(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] q, input logic pe, input exp_t e);
    n_cmp++;
    if (q !== e.q || pe !== e.pe) begin
      n_fail++;
      $display("FAIL %s: got q=%h perr=%b expected q=%h perr=%b", nm, q, pe, e.q, e.pe);
    end
  endtask

  task automatic extra(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: q_vld with no access outstanding", nm);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (bus0.q_vld_a) begin
        if (sb_a0.size() == 0) extra("a0"); else chk("a0", bus0.q_a, bus0.par_err_a, sb_a0.pop_front());
      end
      if (bus0.q_vld_b) begin
        if (sb_b0.size() == 0) extra("b0"); else chk("b0", bus0.q_b, bus0.par_err_b, sb_b0.pop_front());
      end
      if (bus1.q_vld_a) begin
        if (sb_a1.size() == 0) extra("a1"); else chk("a1", bus1.q_a, bus1.par_err_a, sb_a1.pop_front());
      end
      if (bus1.q_vld_b) begin
        if (sb_b1.size() == 0) extra("b1"); else chk("b1", bus1.q_b, bus1.par_err_b, sb_b1.pop_front());
      end
    end
  end

  // Applied at a falling edge; returns at the next falling edge.
  task automatic drive(input vec_t v);
    bus0.en_a = v.en_a; bus0.we_a = v.we_a; bus0.be_a = v.be_a; bus0.adr_a = v.adr_a;
    bus0.d_a = v.d_a; bus0.par_inj_a = v.inj;
    bus0.en_b = v.en_b; bus0.we_b = v.we_b; bus0.be_b = v.be_b; bus0.adr_b = v.adr_b;
    bus0.d_b = v.d_b;
    if (v.en_a) begin
      sb_a0.push_back('{q: v.qa0, pe: PAR_EN & v.perr[3]});
      sb_a1.push_back('{q: v.qa1, pe: PAR_EN & v.perr[1]});
    end
    if (v.en_b) begin
      sb_b0.push_back('{q: v.qb0, pe: PAR_EN & v.perr[2]});
      sb_b1.push_back('{q: v.qb1, pe: PAR_EN & v.perr[0]});
    end
    @(negedge clk);
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    while (bus0.init_busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    cmp(nm, n, 512);
    cmp({nm, "_dut1"}, {31'd0, bus1.init_busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    idle_v = '{default: '0};
    vec[0]  = '{1,0,4'h0,0,0,0,           1,0,4'h0,255,0,           0,0,0,0,4'b0000};
    vec[1]  = '{1,0,4'h0,511,0,0,         0,0,4'h0,0,0,             0,0,0,0,4'b0000};
    vec[2]  = '{1,1,4'hF,5,32'hDEADBEEF,0,0,0,4'h0,0,0,             0,0,32'hDEADBEEF,0,4'b0000};
    vec[3]  = '{0,0,4'h0,0,0,0,           1,1,4'h5,5,32'h11223344,  0,32'hDEADBEEF,0,32'hDE22BE44,4'b0000};
    vec[4]  = '{1,0,4'h0,5,0,0,           0,0,4'h0,0,0,             32'hDE22BE44,0,32'hDE22BE44,0,4'b0000};
    vec[5]  = '{1,1,4'hF,7,32'hAAAAAAAA,0,1,0,4'h0,7,0,             0,0,32'hAAAAAAAA,32'hAAAAAAAA,4'b0000};
    vec[6]  = '{1,1,4'h1,9,32'h000000FF,0,1,1,4'hF,9,32'hFFFFFF00,  0,0,32'hFFFFFFFF,32'hFFFFFFFF,4'b0000};
    vec[7]  = '{1,0,4'h0,9,0,0,           1,0,4'h0,7,0,             32'hFFFFFFFF,32'hAAAAAAAA,32'hFFFFFFFF,32'hAAAAAAAA,4'b0000};
    vec[8]  = '{1,1,4'hF,9,32'h000000FF,0,1,1,4'hF,9,32'hFFFFFF00,  32'hFFFFFFFF,32'hFFFFFFFF,32'h000000FF,32'h000000FF,4'b0000};
    vec[9]  = '{1,0,4'h0,5,0,0,           1,0,4'h0,9,0,             32'hDE22BE44,32'h000000FF,32'hDE22BE44,32'h000000FF,4'b0000};
    vec[10] = '{1,1,4'hF,3,32'h12345678,1,0,0,4'h0,0,0,             0,0,32'h12345678,0,4'b0010};
    vec[11] = '{0,0,4'h0,0,0,0,           1,0,4'h0,3,0,             0,32'h12345678,0,32'h12345678,4'b0101};
    vec[12] = '{1,1,4'hF,3,32'h12345678,0,0,0,4'h0,0,0,             32'h12345678,0,32'h12345678,0,4'b1000};
    vec[13] = '{0,0,4'h0,0,0,0,           1,0,4'h0,3,0,             0,32'h12345678,0,32'h12345678,4'b0000};
    vec[14] = '{1,1,4'h6,20,32'hCAFEF00D,0,1,0,4'h0,20,0,           0,0,32'h00FEF000,32'h00FEF000,4'b0000};
    vec[15] = '{1,0,4'h0,20,0,0,          1,0,4'h0,9,0,             32'h00FEF000,32'h000000FF,32'h00FEF000,32'h000000FF,4'b0000};

    bus0.clr = 1'b0;
    rst_n = 1'b0;
    drive(idle_v);
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst_q_a", bus0.q_a, 0);
    cmp("rst_q_b1", bus1.q_b, 0);
    cmp("rst_vld", {28'd0, bus0.q_vld_a, bus0.q_vld_b, bus1.q_vld_a, bus1.q_vld_b}, 0);
    cmp("rst_perr", {30'd0, bus0.par_err_b, bus1.par_err_b}, 0);
    cmp("rst_busy", {31'd0, bus0.init_busy}, 1);
    rst_n = 1'b1;
    count_busy("init_len");

    mon_on = 1'b1;
    for (int i = 0; i < 16; i++) drive(vec[i]);
    repeat (3) drive(idle_v);
    cmp("hold_q_a", bus0.q_a, 32'h00FEF000);
    cmp("hold_q_b", bus0.q_b, 32'h000000FF);
    cmp("hold_vld", {30'd0, bus0.q_vld_a, bus1.q_vld_a}, 0);

    // Latency: dut0 strobes one cycle after the access, dut1 two.
    v = idle_v;
    v.en_a = 1'b1; v.adr_a = 9'd5; v.qa0 = 32'hDE22BE44; v.qa1 = 32'hDE22BE44;
    drive(v);
    cmp("lat_n1", {30'd0, bus0.q_vld_a, bus1.q_vld_a}, 32'b10);
    drive(idle_v);
    cmp("lat_n2", {30'd0, bus0.q_vld_a, bus1.q_vld_a}, 32'b01);
    drive(idle_v);
    cmp("lat_n3", {30'd0, bus0.q_vld_a, bus1.q_vld_a}, 32'b00);

    // clr right behind a read: the read completes, the clr-cycle access is dropped.
    v = idle_v;
    v.en_a = 1'b1; v.adr_a = 9'd9; v.qa0 = 32'h000000FF; v.qa1 = 32'h000000FF;
    drive(v);
    v = idle_v;
    v.en_a = 1'b1; v.we_a = 1'b1; v.be_a = 4'hF; v.adr_a = 9'd30; v.d_a = 32'h5A5A5A5A;
    bus0.clr = 1'b1;
    bus0.en_a = v.en_a; bus0.we_a = v.we_a; bus0.be_a = v.be_a; bus0.adr_a = v.adr_a; bus0.d_a = v.d_a;
    bus0.en_b = 1'b1; bus0.we_b = 1'b0; bus0.adr_b = 9'd9;
    @(negedge clk);
    bus0.clr = 1'b0;
    bus0.en_a = 1'b0; bus0.we_a = 1'b0; bus0.en_b = 1'b0;
    count_busy("clr_len");

    for (int i = 0; i < 512; i++) begin
      v = idle_v;
      v.en_a = 1'b1; v.adr_a = 9'(i);
      v.en_b = 1'b1; v.adr_b = 9'(511 - i);
      drive(v);
    end
    repeat (4) drive(idle_v);
    cmp("sb_a0_empty", sb_a0.size(), 0);
    cmp("sb_b0_empty", sb_b0.size(), 0);
    cmp("sb_a1_empty", sb_a1.size(), 0);
    cmp("sb_b1_empty", sb_b1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
